// File: rtl/riscv_merge_arbiter_pkg.sv
// Shared definitions for the 2:1 packet merge arbiter: FSM encoding, source ids, counter width.
package riscv_merge_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1
  } arb_state_e;

  localparam logic        SRC_DATA  = 1'b0;
  localparam logic        SRC_RISCV = 1'b1;
  localparam int unsigned CNT_WIDTH = 32;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output register stage: one-cycle latency, full throughput, registered input ready.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  assign push        = in_valid_i & ready_q;
  assign pop         = out_valid_o & out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign in_ready_o  = ready_q;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Ready is taken from the next occupancy so it never depends on out_ready_i combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/riscv_merge_arbiter.sv
// Packet-granular 2:1 AXI-Stream merge of datapath (input 0) and RISC-V return traffic (input 1).
module riscv_merge_arbiter
  import riscv_merge_arbiter_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned PRIO_RISCV           = 0,
  parameter int unsigned MAX_CONSEC           = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s0_axis_tuser,
  input  logic                                 s0_axis_tvalid,
  input  logic                                 s0_axis_tlast,
  output logic                                 s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s1_axis_tuser,
  input  logic                                 s1_axis_tvalid,
  input  logic                                 s1_axis_tlast,
  output logic                                 s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [CNT_WIDTH-1:0]                 pkt_cnt0,
  output logic [CNT_WIDTH-1:0]                 pkt_cnt1
);

  localparam int unsigned KeepWidth = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned BeatWidth = C_S_AXIS_DATA_WIDTH + KeepWidth + C_S_AXIS_TUSER_WIDTH + 1;
  localparam logic [7:0]  MaxConsec = 8'(MAX_CONSEC);

  arb_state_e           state_q, state_d;
  logic                 last_served_q, last_served_d;
  logic [7:0]           consec_q, consec_d;
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d;
  logic                 buf_ready, sel_valid, done0, done1;
  logic [BeatWidth-1:0] sel_beat, out_beat;

  assign s0_axis_tready = (state_q == StGrant0) & buf_ready;
  assign s1_axis_tready = (state_q == StGrant1) & buf_ready;
  assign done0          = s0_axis_tvalid & s0_axis_tready & s0_axis_tlast;
  assign done1          = s1_axis_tvalid & s1_axis_tready & s1_axis_tlast;

  always_comb begin
    sel_valid = 1'b0;
    sel_beat  = {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast};
    unique case (state_q)
      StGrant0: sel_valid = s0_axis_tvalid;
      StGrant1: begin
        sel_valid = s1_axis_tvalid;
        sel_beat  = {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast};
      end
      default: sel_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    consec_d      = consec_q;
    pkt_cnt0_d    = pkt_cnt0_q;
    pkt_cnt1_d    = pkt_cnt1_q;
    unique case (state_q)
      StIdle: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          if (PRIO_RISCV != 0) begin
            state_d = (consec_q == MaxConsec) ? StGrant0 : StGrant1;
          end else begin
            state_d = (last_served_q == SRC_RISCV) ? StGrant0 : StGrant1;
          end
        end else if (s0_axis_tvalid) begin
          state_d = StGrant0;
        end else if (s1_axis_tvalid) begin
          state_d = StGrant1;
        end
      end
      StGrant0: begin
        if (done0) begin
          state_d       = StIdle;
          last_served_d = SRC_DATA;
          consec_d      = 8'd0;
          pkt_cnt0_d    = pkt_cnt0_q + CNT_WIDTH'(1);
        end
      end
      StGrant1: begin
        if (done1) begin
          state_d       = StIdle;
          last_served_d = SRC_RISCV;
          pkt_cnt1_d    = pkt_cnt1_q + CNT_WIDTH'(1);
          // Only packets that made input 0 wait count toward the fairness cap.
          if (s0_axis_tvalid && (consec_q != MaxConsec)) consec_d = consec_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_served_q <= SRC_RISCV;
      consec_q      <= 8'd0;
      pkt_cnt0_q    <= '0;
      pkt_cnt1_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      consec_q      <= consec_d;
      pkt_cnt0_q    <= pkt_cnt0_d;
      pkt_cnt1_q    <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

  axis_skid_buffer #(
    .Width(BeatWidth)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (sel_beat),
    .in_valid_i (sel_valid),
    .in_ready_o (buf_ready),
    .out_data_o (out_beat),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_beat;

endmodule

// File: tb/tb_riscv_merge_arbiter.sv
// Bench: round-robin instance (dut_a) and RISC-V-priority instance (dut_b) against a packet-level model.
module tb_riscv_merge_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  beat_t         s_beat [4];
  logic [3:0]    s_valid;
  logic [3:0]    s_ready;
  logic [1:0]    m_valid;
  logic [1:0]    m_ready;
  logic [DW-1:0] ma_data, mb_data;
  logic [KW-1:0] ma_keep, mb_keep;
  logic [UW-1:0] ma_user, mb_user;
  logic          ma_last, mb_last;
  logic [31:0]   cnt_a0, cnt_a1, cnt_b0, cnt_b1;
  beat_t         m_beat_a, m_beat_b;

  assign m_beat_a = {ma_data, ma_keep, ma_user, ma_last};
  assign m_beat_b = {mb_data, mb_keep, mb_user, mb_last};

  riscv_merge_arbiter #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .PRIO_RISCV(0), .MAX_CONSEC(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s_beat[0].data), .s0_axis_tkeep(s_beat[0].keep),
    .s0_axis_tuser(s_beat[0].user), .s0_axis_tvalid(s_valid[0]),
    .s0_axis_tlast(s_beat[0].last), .s0_axis_tready(s_ready[0]),
    .s1_axis_tdata(s_beat[1].data), .s1_axis_tkeep(s_beat[1].keep),
    .s1_axis_tuser(s_beat[1].user), .s1_axis_tvalid(s_valid[1]),
    .s1_axis_tlast(s_beat[1].last), .s1_axis_tready(s_ready[1]),
    .m_axis_tdata(ma_data), .m_axis_tkeep(ma_keep), .m_axis_tuser(ma_user),
    .m_axis_tvalid(m_valid[0]), .m_axis_tlast(ma_last), .m_axis_tready(m_ready[0]),
    .pkt_cnt0(cnt_a0), .pkt_cnt1(cnt_a1)
  );

  riscv_merge_arbiter #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .PRIO_RISCV(1), .MAX_CONSEC(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s_beat[2].data), .s0_axis_tkeep(s_beat[2].keep),
    .s0_axis_tuser(s_beat[2].user), .s0_axis_tvalid(s_valid[2]),
    .s0_axis_tlast(s_beat[2].last), .s0_axis_tready(s_ready[2]),
    .s1_axis_tdata(s_beat[3].data), .s1_axis_tkeep(s_beat[3].keep),
    .s1_axis_tuser(s_beat[3].user), .s1_axis_tvalid(s_valid[3]),
    .s1_axis_tlast(s_beat[3].last), .s1_axis_tready(s_ready[3]),
    .m_axis_tdata(mb_data), .m_axis_tkeep(mb_keep), .m_axis_tuser(mb_user),
    .m_axis_tvalid(m_valid[1]), .m_axis_tlast(mb_last), .m_axis_tready(m_ready[1]),
    .pkt_cnt0(cnt_b0), .pkt_cnt1(cnt_b1)
  );

  beat_t src_q [4][$];   // beats still to be offered by each upstream source
  beat_t pend  [4][$];   // same beats, consumed by the reference model
  beat_t out_q [2][$];   // beats observed on each merged output
  int    out_cyc [2][$];
  beat_t exp_q [$];
  int    acc_cnt [4];
  bit    hs [4];
  int    mode [2];       // 0: always ready, 1: random ready, 2: stalled
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;

  // Upstream sources and downstream sinks, all updated on the falling edge.
  initial begin
    s_valid = '0;
    m_ready = '0;
    for (int i = 0; i < 4; i++) begin
      s_beat[i] = '0;
      hs[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          hs[i] = 1'b0;
          s_valid[i] = 1'b0;
        end else begin
          if (hs[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
            acc_cnt[i]++;
          end
          if (src_q[i].size() > 0) begin
            s_beat[i] = src_q[i][0];
            s_valid[i] = 1'b1;
          end else begin
            s_valid[i] = 1'b0;
          end
          hs[i] = s_valid[i] && s_ready[i];
        end
      end
      for (int d = 0; d < 2; d++) begin
        case (mode[d])
          0: m_ready[d] = 1'b1;
          1: m_ready[d] = ($urandom_range(0, 3) != 0);
          default: m_ready[d] = 1'b0;
        endcase
        if (!rst && m_valid[d] && m_ready[d]) begin
          out_q[d].push_back((d == 0) ? m_beat_a : m_beat_b);
          out_cyc[d].push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic clear_state();
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      pend[i].delete();
      acc_cnt[i] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      out_q[d].delete();
      out_cyc[d].delete();
      mode[d] = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    clear_state();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add_pkt(input int src, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = {$urandom, $urandom};
      bt.keep = KW'($urandom);
      bt.user = UW'($urandom);
      bt.last = (b == len - 1);
      src_q[src].push_back(bt);
      pend[src].push_back(bt);
    end
  endtask

  // Packet-level reference: decides whole-packet order from the arbitration rules.
  task automatic build_exp(input int d, input bit prio, input int maxc);
    int    n [2];
    int    last_src, consec, w;
    beat_t bt;
    exp_q.delete();
    for (int s = 0; s < 2; s++) begin
      n[s] = 0;
      for (int k = 0; k < pend[2*d+s].size(); k++) if (pend[2*d+s][k].last) n[s]++;
    end
    last_src = 1;
    consec = 0;
    while (n[0] > 0 || n[1] > 0) begin
      if (n[0] > 0 && n[1] > 0) begin
        if (prio) w = (consec == maxc) ? 0 : 1;
        else      w = (last_src == 1) ? 0 : 1;
      end else begin
        w = (n[0] > 0) ? 0 : 1;
      end
      do begin
        bt = pend[2*d+w].pop_front();
        exp_q.push_back(bt);
      end while (!bt.last);
      n[w]--;
      if (w == 1) begin
        if (n[0] > 0 && consec < maxc) consec++;
      end else begin
        consec = 0;
      end
      last_src = w;
    end
  endtask

  task automatic check_stream(input int d, input string name);
    int n;
    n = exp_q.size();
    for (int i = 0; i < 4000 && out_q[d].size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (out_q[d].size() != n) begin
      fails++;
      $display("FAIL %s beat count: got %0d expected %0d", name, out_q[d].size(), n);
    end
    for (int k = 0; k < n && k < out_q[d].size(); k++) begin
      tests++;
      if (out_q[d][k] !== exp_q[k]) begin
        fails++;
        $display("FAIL %s beat %0d: got %h expected %h", name, k, out_q[d][k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (m_valid !== 2'b00) begin
      fails++; $display("FAIL reset m_tvalid: got %b expected 00", m_valid);
    end
    tests++;
    if (s_ready !== 4'b0000) begin
      fails++; $display("FAIL reset s_tready: got %b expected 0000", s_ready);
    end
    tests++;
    if ({cnt_a0, cnt_a1, cnt_b0, cnt_b1} !== 128'd0) begin
      fails++; $display("FAIL reset counters: got %h %h %h %h expected 0", cnt_a0, cnt_a1, cnt_b0, cnt_b1);
    end
    do_reset();
    @(posedge clk);
    #1;
    tests++;
    if (s_ready !== 4'b0000 || m_valid !== 2'b00) begin
      fails++; $display("FAIL idle after release: got ready %b valid %b expected 0", s_ready, m_valid);
    end
  endtask

  task automatic test_s0_only();
    int gap, want;
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(0, 4);
    build_exp(0, 1'b0, 4);
    check_stream(0, "s0_only");
    for (int k = 1; k < 12 && k < out_cyc[0].size(); k++) begin
      gap = out_cyc[0][k] - out_cyc[0][k-1];
      want = (k % 4 == 0) ? 2 : 1;
      tests++;
      if (gap != want) begin
        fails++; $display("FAIL s0_only spacing beat %0d: got %0d expected %0d", k, gap, want);
      end
    end
    tests++;
    if (cnt_a0 !== 32'd3 || cnt_a1 !== 32'd0) begin
      fails++; $display("FAIL s0_only counters: got %0d/%0d expected 3/0", cnt_a0, cnt_a1);
    end
  endtask

  task automatic test_rr_alternate();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 1);
      add_pkt(1, 1);
    end
    build_exp(0, 1'b0, 4);
    check_stream(0, "rr_alternate");
    tests++;
    if (cnt_a0 !== 32'd4 || cnt_a1 !== 32'd4) begin
      fails++; $display("FAIL rr_alternate counters: got %0d/%0d expected 4/4", cnt_a0, cnt_a1);
    end
  endtask

  task automatic test_prio_cap();
    do_reset();
    mode[1] = 1;
    for (int p = 0; p < 3; p++) add_pkt(2, 1);
    for (int p = 0; p < 12; p++) add_pkt(3, 1);
    build_exp(1, 1'b1, 4);
    check_stream(1, "prio_cap");
    tests++;
    if (cnt_b0 !== 32'd3 || cnt_b1 !== 32'd12) begin
      fails++; $display("FAIL prio_cap counters: got %0d/%0d expected 3/12", cnt_b0, cnt_b1);
    end
  endtask

  task automatic test_random();
    int n0, n1;
    for (int it = 0; it < 4; it++) begin
      int d;
      d = it % 2;
      do_reset();
      mode[d] = 1;
      n0 = $urandom_range(1, 5);
      n1 = $urandom_range(1, 5);
      for (int p = 0; p < n0; p++) add_pkt(2*d, $urandom_range(1, 6));
      for (int p = 0; p < n1; p++) add_pkt(2*d+1, $urandom_range(1, 6));
      build_exp(d, (d == 1), 4);
      check_stream(d, (d == 0) ? "random_rr" : "random_prio");
      tests++;
      if ((d == 0 && (cnt_a0 != n0 || cnt_a1 != n1)) || (d == 1 && (cnt_b0 != n0 || cnt_b1 != n1)))
      begin
        fails++;
        $display("FAIL random counters dut %0d: got %0d/%0d %0d/%0d expected %0d/%0d",
                 d, cnt_a0, cnt_a1, cnt_b0, cnt_b1, n0, n1);
      end
    end
  endtask

  task automatic test_backpressure();
    int    snap;
    beat_t held;
    do_reset();
    add_pkt(1, 8);
    for (int i = 0; i < 200 && out_q[0].size() < 2; i++) @(posedge clk);
    #1;
    snap = acc_cnt[1];
    mode[0] = 2;
    @(negedge clk);
    @(posedge clk);
    #1;
    held = m_beat_a;
    repeat (4) begin
      @(posedge clk);
      #1;
      tests++;
      if (m_beat_a !== held || m_valid[0] !== 1'b1) begin
        fails++; $display("FAIL stall stability: got %h v=%b expected %h v=1", m_beat_a, m_valid[0], held);
      end
    end
    tests++;
    if (s_ready[1] !== 1'b0) begin
      fails++; $display("FAIL stall s1_tready: got %b expected 0", s_ready[1]);
    end
    tests++;
    if (acc_cnt[1] - snap > 2) begin
      fails++; $display("FAIL stall absorbed beats: got %0d expected at most 2", acc_cnt[1] - snap);
    end
    mode[0] = 0;
    build_exp(0, 1'b0, 4);
    check_stream(0, "backpressure");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_cnt;
    do_reset();
    @(posedge clk);
    #1 force dut_a.pkt_cnt0_q = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 release dut_a.pkt_cnt0_q;
    exp_cnt = 32'hFFFF_FFFF;
    exp_cnt = exp_cnt + 32'd1;
    add_pkt(0, 2);
    build_exp(0, 1'b0, 4);
    check_stream(0, "wrap");
    tests++;
    if (cnt_a0 !== exp_cnt || cnt_a1 !== 32'd0) begin
      fails++; $display("FAIL wrap counter: got %h/%h expected %h/0", cnt_a0, cnt_a1, exp_cnt);
    end
  endtask

  task automatic test_reset_midpkt();
    do_reset();
    add_pkt(0, 6);
    for (int i = 0; i < 200 && out_q[0].size() < 2; i++) @(posedge clk);
    #1;
    tests++;
    if (m_valid[0] !== 1'b1) begin
      fails++; $display("FAIL midpkt beat3 present: got %b expected 1", m_valid[0]);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
      fails++; $display("FAIL midpkt async clear: got valid %b ready %b expected 0/0", m_valid[0], s_ready[0]);
    end
    clear_state();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++;
    if (cnt_a0 !== 32'd0) begin
      fails++; $display("FAIL midpkt counter: got %0d expected 0", cnt_a0);
    end
    add_pkt(0, 3);
    build_exp(0, 1'b0, 4);
    check_stream(0, "post_reset");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) mode[d] = 0;
    test_reset();
    test_s0_only();
    test_rr_alternate();
    test_prio_cap();
    test_backpressure();
    test_wrap();
    test_reset_midpkt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
